dot_product_acc: RTL and testbench
==================================

DOT_PRODUCT_ACC -- requirements
Module: dot_product_acc

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel multiply lanes per beat.
REQ-002 SHALL have parameter DW, default 16, unsigned fixed-point operand and result width.
REQ-003 SHALL have parameter FRAC, default 8, fraction bits per operand (Q8.8 at default).
REQ-004 SHALL have parameter ACC_W, default 32, accumulator width; ACC_W >= DW.
REQ-005 SHALL have parameter CNT_W, default 8, beat-counter width.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, operand beat valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-010 SHALL have port in_a, input, LANES*DW, packed operand A; lane 0 in the most-significant DW bits.
REQ-011 SHALL have port in_b, input, LANES*DW, packed operand B; same packing as in_a.
REQ-012 SHALL have port in_last, input, 1, marks the final beat of a vector.
REQ-013 SHALL have port out_valid, output, 1, result valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-015 SHALL have port out_data, output, DW, dot-product result.
REQ-016 SHALL have port out_beats, output, CNT_W, number of beats in the completed vector.
REQ-017 SHALL have port out_sat, output, 1, result was clipped.

Function
REQ-018 SHALL accept a beat only when in_valid && in_ready are both high in the same cycle.
REQ-019 Per lane, SHALL compute the unsigned product a_i*b_i (2*DW bits) and shift it right by FRAC (truncating), keeping 2*DW-FRAC bits.
REQ-020 Stage 1 SHALL register the LANES truncated products and the last flag.
REQ-021 Stage 2 SHALL add the lane sum to the accumulator; addition wraps modulo 2^ACC_W.
REQ-022 State machine: IDLE (no beat pending), ACC (at least one beat accepted, no last), FLUSH (last beat in the pipeline), HOLD (out_valid high).
REQ-023 Transitions: IDLE->ACC on a non-last beat; IDLE/ACC->FLUSH on a last beat; FLUSH->HOLD after 2 cycles; HOLD->IDLE on out_valid && out_ready.
REQ-024 in_ready SHALL be high in IDLE and ACC, and low in FLUSH and HOLD.
REQ-025 Latency: last beat accepted in cycle N -> out_valid high in cycle N+2; in_ready returns high in the cycle after the output handshake.
REQ-026 out_data, out_beats and out_sat SHALL stay stable while out_valid is high and out_ready is low.
REQ-027 When an output handshake completes, the accumulator and beat counter SHALL be cleared for the next vector.
REQ-028 The beat counter SHALL count accepted beats including the last, saturating at 2^CNT_W-1.
REQ-029 Back-to-back beats with in_valid held high SHALL be accepted one per cycle, without bubbles, while in ACC.

Reset
REQ-030 On rst high at a clock edge: state IDLE, accumulator 0, counter 0, pipeline flags 0, out_valid 0, out_data 0, out_beats 0, out_sat 0.
REQ-031 in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset.
REQ-032 Reset mid-vector or during HOLD SHALL discard partial and pending results; no out_valid pulse follows.

Configuration
REQ-033 With macro DOTP_SAT_EN defined: if the accumulator exceeds 2^DW-1, out_data SHALL be 2^DW-1 and out_sat SHALL be 1.
REQ-034 Without DOTP_SAT_EN: out_data SHALL be the accumulator bits [DW-1:0], and out_sat SHALL be tied 0.

Verification
REQ-035 Reset test: LANES=4, in_a lanes all 0x0100, in_b lanes all 0x0200, one beat with in_last -> out_data 0x0800, out_beats 1, out_valid 2 cycles after acceptance.
REQ-036 Two-beat test: same operands for 2 consecutive beats, in_last on the second -> out_data 0x1000, out_beats 2.
REQ-037 Backpressure test: out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready 0 throughout, then IDLE the cycle after handshake.
REQ-038 Overflow test: all lanes a=b=0xFFFF, one last beat -> DOTP_SAT_EN: out_data 0xFFFF, out_sat 1; no macro: out_data 0xF800, out_sat 0.
REQ-039 Reset test: rst pulsed after 3 of 5 beats, then a fresh 1-beat vector of 0x0100 x 0x0100 -> out_data 0x0400, out_beats 1.
REQ-040 Idle test: in_valid 0 for 10 cycles -> out_valid stays 0 and the accumulator is unchanged.

Source files
------------

// File: rtl/dot_product_acc.sv
// dot_product_acc -- streaming fixed-point dot-product accumulator.
//
// Each accepted beat carries LANES unsigned Q(DW-FRAC).FRAC operand pairs.
// Stage 1 registers the per-lane truncated products (a*b >> FRAC).
// Stage 2 adds their sum into an ACC_W-bit wrapping accumulator.
// A beat flagged in_last closes the vector. The result is presented on
// out_data/out_beats/out_sat and held until out_ready is seen.
//
// Optional feature: define DOTP_SAT_EN to clip results above 2^DW-1.
// When clipped, out_data is forced to all ones and out_sat is raised.
// Without the macro, out_data is the low DW accumulator bits and
// out_sat is always 0.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operand beat handshake
//   in_a, in_b         packed operands, lane 0 in the most-significant DW bits
//   in_last            final beat of the vector
//   out_valid/out_ready result handshake
//   out_data           dot-product result (DW bits)
//   out_beats          accepted beats in the vector (saturating)
//   out_sat            result was clipped
module dot_product_acc #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_a,
  input  logic [LANES*DW-1:0] in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [CNT_W-1:0]    out_beats,
  output logic                out_sat
);

  localparam int unsigned PW = 2*DW - FRAC;

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, HOLD} state_t;

  state_t           state;
  logic             ready_q;
  logic             accept;
  logic             handshake;

  logic [DW-1:0]    a_l, b_l;
  logic [2*DW-1:0]  full;
  logic [PW-1:0]    prod    [LANES];
  logic [PW-1:0]    s1_prod [LANES];
  logic             s1_valid;
  logic             s1_last;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] lane_sum;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;

  logic [DW-1:0]    res_data;
  logic             sat_hit;

  // The registered ready is masked by rst so it reads 0 in the reset cycle.
  // It still reads 1 in the first cycle after reset.
  assign in_ready  = ready_q & ~rst;
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  always_comb begin
    a_l  = '0;
    b_l  = '0;
    full = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a_l     = in_a[(LANES-1-i)*DW +: DW];
      b_l     = in_b[(LANES-1-i)*DW +: DW];
      full    = (2*DW)'(a_l) * (2*DW)'(b_l);
      prod[i] = PW'(full >> FRAC);
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + ACC_W'(s1_prod[i]);
    end
    acc_sum = acc + lane_sum;
  end

`ifdef DOTP_SAT_EN
  localparam logic [ACC_W-1:0] DMAX = ACC_W'({DW{1'b1}});
  always_comb begin
    sat_hit  = (acc_sum > DMAX);
    res_data = sat_hit ? '1 : acc_sum[DW-1:0];
  end
`else
  always_comb begin
    sat_hit  = 1'b0;
    res_data = acc_sum[DW-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) s1_prod[i] <= '0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept & in_last;
      if (accept) begin
        for (int unsigned i = 0; i < LANES; i++) s1_prod[i] <= prod[i];
      end

      if (handshake)     acc <= '0;
      else if (s1_valid) acc <= acc_sum;

      if (handshake)                 cnt <= '0;
      else if (accept && cnt != '1)  cnt <= cnt + 1'b1;

      case (state)
        IDLE, ACC: begin
          if (accept) begin
            if (in_last) begin
              state   <= FLUSH;
              ready_q <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        // The last beat's products sit in stage 1 here. acc_sum already
        // includes them, so the result is captured as acc is updated.
        FLUSH: begin
          if (s1_valid && s1_last) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_beats <= cnt;
            out_sat   <= sat_hit;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ready_q   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_acc.sv
module tb_dot_product_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_beats;
  logic        out_sat;

  always #5 clk = ~clk;

  dot_product_acc #(
    .LANES(4), .DW(16), .FRAC(8), .ACC_W(32), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beats(out_beats), .out_sat(out_sat)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  n;
    logic        s;
  } exp_t;

  exp_t        sb[$];
  exp_t        pk;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] m_acc = '0;
  logic [7:0]  m_beats = '0;
  int          w;
  logic [15:0] held;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [31:0] lane_sum(input logic [63:0] a, input logic [63:0] b);
    logic [31:0] s;
    logic [31:0] p;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      p = 32'(a[(3-i)*16 +: 16]) * 32'(b[(3-i)*16 +: 16]);
      s = s + (p >> 8);
    end
    return s;
  endfunction

  // Drive one beat and track the reference model. `waited` returns the
  // cycles spent before in_ready allowed acceptance.
  task automatic send_beat(input logic [63:0] a, input logic [63:0] b,
                           input logic last, output int waited);
    exp_t e;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 64) begin
      tick;
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_acc = m_acc + lane_sum(a, b);
    if (m_beats != 8'hFF) m_beats = m_beats + 8'd1;
    if (last) begin
`ifdef DOTP_SAT_EN
      if (m_acc > 32'h0000_FFFF) begin e.d = 16'hFFFF; e.s = 1'b1; end
      else begin e.d = m_acc[15:0]; e.s = 1'b0; end
`else
      e.d = m_acc[15:0];
      e.s = 1'b0;
`endif
      e.n = m_beats;
      sb.push_back(e);
      m_acc   = '0;
      m_beats = '0;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    if (!out_valid) chk(tag, 32'(out_valid), 32'd1);
  endtask

  // Compare the presented result against the scoreboard head and pop it.
  task automatic collect(input string tag);
    exp_t e;
    wait_valid({tag, "_timeout"});
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"},  32'(out_data),  32'(e.d));
      chk({tag, "_beats"}, 32'(out_beats), 32'(e.n));
      chk({tag, "_sat"},   32'(out_sat),   32'(e.s));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    tick;
    tick;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_beats", 32'(out_beats), 32'd0);
    chk("rst_out_sat",   32'(out_sat),   32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single last beat: out_valid exactly two cycles after acceptance.
    send_beat(rep(16'h0100), rep(16'h0200), 1'b1, w);
    chk("lat_n1_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick;
    chk("lat_n2_valid", 32'(out_valid), 32'd1);
    chk("one_beat_const", 32'(out_data), 32'h0800);
    collect("one_beat");
    tick;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_valid", 32'(out_valid), 32'd0);

    // Two back-to-back beats.
    send_beat(rep(16'h0100), rep(16'h0200), 1'b0, w);
    send_beat(rep(16'h0100), rep(16'h0200), 1'b1, w);
    chk("no_bubble", 32'(w), 32'd0);
    wait_valid("two_beat_wait");
    chk("two_beat_const", 32'(out_data), 32'h1000);
    collect("two_beat");
    tick;

    // Distinct lane values.
    send_beat({16'h0100, 16'h0200, 16'h0300, 16'h0400},
              {16'h0180, 16'h0080, 16'h0010, 16'h0001}, 1'b1, w);
    collect("mixed_lanes");
    tick;

    // Backpressure: the result must hold while out_ready is low.
    out_ready = 1'b0;
    send_beat(rep(16'h0300), rep(16'h0100), 1'b1, w);
    wait_valid("bp_wait");
    held = out_data;
    pk = (sb.size() != 0) ? sb[0] : '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'(pk.d));
      chk("bp_stable", 32'(out_data), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick;
    end
    out_ready = 1'b1;
    collect("bp");
    tick;
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);

    // Overflow.
    send_beat(rep(16'hFFFF), rep(16'hFFFF), 1'b1, w);
    wait_valid("ovf_wait");
`ifdef DOTP_SAT_EN
    chk("ovf_const", 32'(out_data), 32'hFFFF);
    chk("ovf_sat_const", 32'(out_sat), 32'd1);
`else
    chk("ovf_const", 32'(out_data), 32'hF800);
    chk("ovf_sat_const", 32'(out_sat), 32'd0);
`endif
    collect("ovf");
    tick;

    // Reset after three of five beats, then a fresh vector.
    for (int i = 0; i < 3; i++) send_beat(rep(16'h0200), rep(16'h0200), 1'b0, w);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_acc = '0;
    m_beats = '0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
      tick;
    end
    send_beat(rep(16'h0100), rep(16'h0100), 1'b1, w);
    wait_valid("midrst_wait");
    chk("midrst_const", 32'(out_data), 32'h0400);
    collect("midrst");
    tick;

    // Reset while holding a result drops it.
    out_ready = 1'b0;
    send_beat(rep(16'h0100), rep(16'h0100), 1'b1, w);
    wait_valid("holdrst_wait");
    rst = 1'b1;
    tick;
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 5; i++) begin
      chk("holdrst_no_valid", 32'(out_valid), 32'd0);
      tick;
    end
    out_ready = 1'b1;

    // Idle: no activity for ten cycles, then a clean vector.
    for (int i = 0; i < 10; i++) begin
      chk("idle_no_valid", 32'(out_valid), 32'd0);
      tick;
    end
    send_beat(rep(16'h0100), rep(16'h0100), 1'b1, w);
    wait_valid("idle_wait");
    chk("idle_const", 32'(out_data), 32'h0400);
    collect("idle_after");
    tick;

    // Beat counter saturates at 255.
    for (int i = 0; i < 260; i++) send_beat(rep(16'h0100), rep(16'h0010), 1'b0, w);
    send_beat(rep(16'h0100), rep(16'h0010), 1'b1, w);
    wait_valid("cnt_sat_wait");
    chk("cnt_sat_const", 32'(out_beats), 32'd255);
    collect("cnt_sat");
    tick;

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
